// File: rtl/sv39_ptw_pkg.sv
// Shared types for the SV39 page-table walker: PTE layout, TLB update record, walker states.
package sv39_ptw_pkg;
  localparam int ASID_WIDTH = 16;
  localparam int PTW_LEVELS = 3;
  localparam int PTESIZE    = 8;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} ptw_state_e;

  typedef struct packed {
    logic [9:0]  reserved;
    logic [43:0] ppn;
    logic [1:0]  rsw;
    logic        d, a, g, u, x, w, r, v;
  } pte_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_2M;
    logic                  is_1G;
    logic [26:0]           vpn;
    logic [ASID_WIDTH-1:0] asid;
    pte_t                  content;
  } tlb_update_t;

  function automatic logic is_canonical(input logic [63:0] va);
    return va[63:39] == {25{va[38]}};
  endfunction
endpackage

// File: rtl/sv39_ptw_if.sv
// PTE read port: req/gnt address phase, one rvalid data beat per grant.
interface sv39_ptw_if #(parameter int PADDR_W = 56) ();
  logic               req;
  logic [PADDR_W-1:0] addr;
  logic               gnt;
  logic               rvalid;
  logic [63:0]        rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/sv39_ptw.sv
// SV39 page-table walker refilling the TLB on a miss; emits a one-cycle update or fault pulse.
// Optional SV39_PTW_PERF_EN adds walk_cycles_o, a saturating count of walking cycles.
module sv39_ptw
  import sv39_ptw_pkg::*;
#(
  parameter int ASID_W  = ASID_WIDTH,
  parameter int PADDR_W = 56
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [43:0]       satp_ppn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [63:0]       req_vaddr_i,
  input  logic [ASID_W-1:0] req_asid_i,
  sv39_ptw_if.master        mem,
  output tlb_update_t       update_o,
  output logic              fault_o,
  output logic [63:0]       fault_vaddr_o,
  output logic              walking_o
`ifdef SV39_PTW_PERF_EN
  , output logic [31:0]     walk_cycles_o
`endif
);

  ptw_state_e        state_q, state_d;
  logic [1:0]        level_q;
  logic [43:0]       ppn_q;
  logic [26:0]       vpn_q;
  logic [ASID_W-1:0] asid_q;
  tlb_update_t       update_q;
  logic              fault_q;
  logic [63:0]       fault_vaddr_q;

  logic accept, upd_fire, flt_fire, descend;
  logic [8:0] vpn_sel;
  pte_t pte;
  logic pte_bad, pte_leaf, misaligned, pte_fault, walk_done;

  assign pte        = pte_t'(mem.rdata);
  assign pte_bad    = !pte.v || (pte.w && !pte.r);
  assign pte_leaf   = pte.r || pte.x;
  assign misaligned = (level_q == 2'd2 && |pte.ppn[17:0]) || (level_q == 2'd1 && |pte.ppn[8:0]);
  // Every terminating PTE is either a fault or a leaf; a pointer at level 0 is a fault too.
  assign pte_fault  = pte_bad || (pte_leaf ? misaligned : (level_q == 2'd0));
  assign walk_done  = pte_bad || pte_leaf || (level_q == 2'd0);

  always_comb begin
    case (level_q)
      2'd2:    vpn_sel = vpn_q[26:18];
      2'd1:    vpn_sel = vpn_q[17:9];
      default: vpn_sel = vpn_q[8:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (req_valid_i && is_canonical(req_vaddr_i)) state_d = REQ;
      REQ: begin
        if (flush_i)       state_d = mem.gnt ? DRAIN : IDLE;
        else if (mem.gnt)  state_d = WAIT;
      end
      // A flush coinciding with rvalid has nothing left in flight, so skip DRAIN.
      WAIT: begin
        if (flush_i)         state_d = mem.rvalid ? IDLE : DRAIN;
        else if (mem.rvalid) state_d = walk_done ? IDLE : REQ;
      end
      DRAIN: if (mem.rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    walking_o   = 1'b1;
    mem.req     = 1'b0;
    mem.addr    = '0;
    accept      = 1'b0;
    upd_fire    = 1'b0;
    flt_fire    = 1'b0;
    descend     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        walking_o   = 1'b0;
        accept      = req_valid_i;
        flt_fire    = req_valid_i && !is_canonical(req_vaddr_i);
      end
      REQ: begin
        mem.req  = 1'b1;
        mem.addr = PADDR_W'({ppn_q, vpn_sel, {$clog2(PTESIZE){1'b0}}});
      end
      WAIT: begin
        if (mem.rvalid && !flush_i) begin
          upd_fire = walk_done && !pte_fault;
          flt_fire = pte_fault;
          descend  = !walk_done;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q       <= '0;
      ppn_q         <= '0;
      vpn_q         <= '0;
      asid_q        <= '0;
      update_q      <= '0;
      fault_q       <= 1'b0;
      fault_vaddr_q <= '0;
    end else begin
      update_q <= '0;
      fault_q  <= flt_fire;
      if (accept) begin
        level_q       <= 2'(PTW_LEVELS - 1);
        ppn_q         <= satp_ppn_i;
        vpn_q         <= req_vaddr_i[38:12];
        asid_q        <= req_asid_i;
        fault_vaddr_q <= req_vaddr_i;
      end
      if (descend) begin
        ppn_q   <= pte.ppn;
        level_q <= level_q - 2'd1;
      end
      if (upd_fire) begin
        update_q.valid   <= 1'b1;
        update_q.is_1G   <= (level_q == 2'd2);
        update_q.is_2M   <= (level_q == 2'd1);
        update_q.vpn     <= vpn_q;
        update_q.asid    <= ASID_WIDTH'(asid_q);
        update_q.content <= pte;
      end
    end
  end

  assign update_o      = update_q;
  assign fault_o       = fault_q;
  assign fault_vaddr_o = fault_vaddr_q;

`ifdef SV39_PTW_PERF_EN
  logic [31:0] walk_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                              walk_cnt_q <= '0;
    else if (walking_o && walk_cnt_q != '1) walk_cnt_q <= walk_cnt_q + 32'd1;
  end
  assign walk_cycles_o = walk_cnt_q;
`endif

endmodule

// File: tb/tb_sv39_ptw.sv
// Directed bench for sv39_ptw: a memory responder checks PTE addresses, a monitor scores update/fault pulses.
module tb_sv39_ptw;
  import sv39_ptw_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, req_valid, req_ready, fault, walking;
  logic [43:0] satp_ppn;
  logic [63:0] req_vaddr, fault_vaddr;
  logic [15:0] req_asid;
  tlb_update_t update;
`ifdef SV39_PTW_PERF_EN
  logic [31:0] walk_cycles;
`endif

  sv39_ptw_if #(.PADDR_W(56)) mem ();

  sv39_ptw #(.ASID_W(ASID_WIDTH), .PADDR_W(56)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .satp_ppn_i(satp_ppn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_vaddr_i(req_vaddr),
    .req_asid_i(req_asid), .mem(mem), .update_o(update), .fault_o(fault),
    .fault_vaddr_o(fault_vaddr), .walking_o(walking)
`ifdef SV39_PTW_PERF_EN
    , .walk_cycles_o(walk_cycles)
`endif
  );

  typedef struct { logic [55:0] addr; logic [63:0] data; int stall; int delay; } rd_t;
  typedef struct { bit flt; logic [63:0] vaddr; logic [15:0] asid; bit is_2M; bit is_1G;
                   logic [63:0] pte; int lat; } exp_t;
  rd_t  mq[$];
  exp_t sq[$];

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mkpte(input logic [43:0] ppn, input logic [7:0] fl);
    return {10'b0, ppn, 2'b0, fl};
  endfunction

  task automatic rd(input logic [55:0] a, input logic [63:0] d, input int stall = 0, input int delay = 0);
    rd_t r;
    r.addr = a; r.data = d; r.stall = stall; r.delay = delay;
    mq.push_back(r);
  endtask

  task automatic exp_upd(input logic [63:0] va, input logic [15:0] asid, input logic [63:0] p,
                         input bit m2, input bit g1, input int lat);
    exp_t e;
    e.flt = 0; e.vaddr = va; e.asid = asid; e.is_2M = m2; e.is_1G = g1; e.pte = p; e.lat = lat;
    sq.push_back(e);
  endtask

  task automatic exp_flt(input logic [63:0] va, input int lat);
    exp_t e;
    e.flt = 1; e.vaddr = va; e.asid = 0; e.is_2M = 0; e.is_1G = 0; e.pte = 0; e.lat = lat;
    sq.push_back(e);
  endtask

  task automatic issue(input logic [63:0] va, input logic [15:0] asid);
    @(negedge clk);
    chk("ready_before_accept", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1; req_vaddr = va; req_asid = asid; acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((sq.size() != 0 || mq.size() != 0 || !req_ready) && n < 200) begin
      @(negedge clk); n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s timeout: pending outputs %0d reads %0d, required 0", name, sq.size(), mq.size());
      sq.delete(); mq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},   {63'b0, req_ready}, 64'd1);
    chk({tag, "_walking"}, {63'b0, walking}, 64'd0);
    chk({tag, "_memreq"},  {63'b0, mem.req}, 64'd0);
    chk({tag, "_memaddr"}, {8'b0, mem.addr}, 64'd0);
    chk({tag, "_update"},  {63'b0, (update == '0)}, 64'd1);
    chk({tag, "_fault"},   {63'b0, fault}, 64'd0);
    chk({tag, "_fvaddr"},  fault_vaddr, 64'd0);
  endtask

  // Memory responder: grants in order, checks each presented address against the expected read.
  initial begin
    bit rsp_pend = 0;
    int rsp_dly = 0;
    logic [63:0] rsp_data = '0;
    rd_t r;
    mem.gnt = 1'b0; mem.rvalid = 1'b0; mem.rdata = '0;
    forever begin
      @(negedge clk);
      mem.rvalid = 1'b0;
      if (rsp_pend) begin
        if (rsp_dly == 0) begin mem.rvalid = 1'b1; mem.rdata = rsp_data; rsp_pend = 0; end
        else rsp_dly--;
      end
      mem.gnt = 1'b0;
      if (mem.req && !rst) begin
        if (mq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_mem_req: addr %h, required no request", mem.addr);
        end else begin
          r = mq[0];
          chk("mem_addr", {8'b0, mem.addr}, {8'b0, r.addr});
          if (r.stall > 0) begin r.stall--; mq[0] = r; end
          else begin
            mem.gnt = 1'b1; rsp_data = r.data; rsp_dly = r.delay; rsp_pend = 1;
            void'(mq.pop_front());
          end
        end
      end
    end
  end

  // Monitor: every update/fault pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (update.valid || fault)) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: update %b fault %b, required none", update.valid, fault);
        end else begin
          e = sq.pop_front();
          chk("out_is_fault", {63'b0, fault}, {63'b0, e.flt});
          chk("latency", 64'(cyc - acc_cyc), 64'(e.lat));
          if (e.flt) begin
            chk("fault_vaddr", fault_vaddr, e.vaddr);
            chk("fault_without_update", {63'b0, update.valid}, 64'd0);
          end else begin
            chk("upd_vpn",   {37'b0, update.vpn}, {37'b0, e.vaddr[38:12]});
            chk("upd_asid",  {48'b0, update.asid}, {48'b0, e.asid});
            chk("upd_is_2M", {63'b0, update.is_2M}, {63'b0, e.is_2M});
            chk("upd_is_1G", {63'b0, update.is_1G}, {63'b0, e.is_1G});
            chk("upd_pte",   update.content, e.pte);
          end
        end
      end
    end
  end

  localparam logic [63:0] VA1  = 64'h0000_0000_4020_1000; // vpn2=1 vpn1=1 vpn0=1
  localparam logic [63:0] VAHI = 64'hFFFF_FFC0_0000_0000; // canonical upper half, vpn2=0x100
  localparam logic [63:0] VAG  = 64'h0000_0000_4000_0000; // vpn2=1, 1G aligned

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_asid = '0;
    satp_ppn = 44'h100;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("reset");

    // 4K walk through three levels
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h300, 8'h01));
    rd(56'h300_008, mkpte(44'h12345, 8'hCF));
    exp_upd(VA1, 16'h0005, mkpte(44'h12345, 8'hCF), 0, 0, 7);
    issue(VA1, 16'h0005);
    wait_idle("walk_4k");

    // 2M leaf at level 1, aligned then misaligned
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h200, 8'h0B));
    exp_upd(VA1, 16'h0006, mkpte(44'h200, 8'h0B), 1, 0, 5);
    issue(VA1, 16'h0006);
    wait_idle("walk_2m");
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h201, 8'h0B));
    exp_flt(VA1, 5);
    issue(VA1, 16'h0006);
    wait_idle("walk_2m_misaligned");

    // invalid PTE at level 2: fault one cycle after rvalid, ready right after
    rd(56'h100_008, 64'h0);
    exp_flt(VA1, 3);
    issue(VA1, 16'h0001);
    @(negedge clk); chk("ready_in_wait", {63'b0, req_ready}, 64'd0);
    @(negedge clk); chk("ready_after_fault", {63'b0, req_ready}, 64'd1);
    wait_idle("invalid_pte");

    // W without R, upper-half address
    rd(56'h100_800, mkpte(44'h5, 8'h05));
    exp_flt(VAHI, 3);
    issue(VAHI, 16'h0002);
    wait_idle("w_without_r");

    // pointer PTE at level 0
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h300, 8'h01));
    rd(56'h300_008, mkpte(44'h400, 8'h01));
    exp_flt(VA1, 7);
    issue(VA1, 16'h0003);
    wait_idle("nonleaf_level0");

    // non-canonical addresses: fault next cycle, no memory access
    exp_flt(64'h0000_8000_0000_0000, 1);
    issue(64'h0000_8000_0000_0000, 16'h0004);
    wait_idle("noncanon_a");
    exp_flt(64'h0000_0040_2030_1000, 1);
    issue(64'h0000_0040_2030_1000, 16'h0004);
    wait_idle("noncanon_b");

    // flush in WAIT at level 1; outstanding rvalid arrives three cycles later
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h200, 8'h0B), 0, 3);
    issue(VA1, 16'h0007);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("drain_ready_0", {63'b0, req_ready}, 64'd0);
    @(negedge clk); chk("drain_ready_1", {63'b0, req_ready}, 64'd0);
    @(negedge clk); chk("drain_ready_2", {63'b0, req_ready}, 64'd0);
    @(negedge clk); chk("ready_after_drain", {63'b0, req_ready}, 64'd1);
    wait_idle("flush_wait");

    // grant stalled 5 cycles on a 1G leaf
    rd(56'h100_008, mkpte(44'h40000, 8'hCF), 5, 0);
    exp_upd(VAG, 16'h0008, mkpte(44'h40000, 8'hCF), 0, 1, 8);
    issue(VAG, 16'h0008);
    wait_idle("gnt_stall");

    // reset mid-REQ, then a fresh walk
    rd(56'h100_008, mkpte(44'h200, 8'h01), 1000, 0);
    issue(VA1, 16'h0009);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midwalk_reset");
    rst = 1'b0;
    mq.delete();
    rd(56'h100_008, mkpte(44'h200, 8'h01));
    rd(56'h200_008, mkpte(44'h200, 8'h0B));
    exp_upd(VA1, 16'h000A, mkpte(44'h200, 8'h0B), 1, 0, 5);
    issue(VA1, 16'h000A);
    wait_idle("after_reset");

    chk("scoreboard_empty", 64'(sq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end
endmodule
